// File: rtl/decode_stage.sv
// Decode stage: turns one fetched RV32I instruction per cycle into register indices,
// an instruction class, a sign-extended immediate and flags. Results are held in a
// main output register backed by one skid register. The skid register lets the stage
// take one more instruction after Execute stalls, so in_ready never depends on ex_ready
// in the same cycle.
module decode_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-3:0] in_addr,
    input  logic [31:0]           in_insn,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [ADDR_WIDTH-3:0] ex_addr,
    output logic [31:0]           ex_insn,
    output logic [3:0]            ex_class,
    output logic [4:0]            ex_rd,
    output logic [4:0]            ex_rs1,
    output logic [4:0]            ex_rs2,
    output logic [31:0]           ex_imm,
    output logic                  ex_is_branch,
    output logic                  ex_illegal
);

    // Instruction class codes seen by Execute
    localparam logic [3:0] CLS_ILLEGAL  = 4'd0;
    localparam logic [3:0] CLS_LUI      = 4'd1;
    localparam logic [3:0] CLS_AUIPC    = 4'd2;
    localparam logic [3:0] CLS_JAL      = 4'd3;
    localparam logic [3:0] CLS_JALR     = 4'd4;
    localparam logic [3:0] CLS_BRANCH   = 4'd5;
    localparam logic [3:0] CLS_LOAD     = 4'd6;
    localparam logic [3:0] CLS_STORE    = 4'd7;
    localparam logic [3:0] CLS_OP_IMM   = 4'd8;
    localparam logic [3:0] CLS_OP       = 4'd9;
    localparam logic [3:0] CLS_MISC_MEM = 4'd10;
    localparam logic [3:0] CLS_SYSTEM   = 4'd11;

    // One decoded instruction as held in either output register
    typedef struct packed {
        logic [ADDR_WIDTH-3:0] addr;
        logic [31:0]           insn;
        logic [3:0]            cls;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [31:0]           imm;
        logic                  is_branch;
        logic                  illegal;
    } dec_t;

    // Pure decode of a raw instruction. Every listed opcode ends in 2'b11, so an
    // instruction with insn[1:0] != 2'b11 falls through to the illegal default.
    function automatic dec_t decode_insn(input logic [31:0] insn,
                                         input logic [ADDR_WIDTH-3:0] addr);
        dec_t        d;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        imm_i = {{20{insn[31]}}, insn[31:20]};
        imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        imm_u = {insn[31:12], 12'b0};
        imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        d.addr      = addr;
        d.insn      = insn;
        d.rd        = insn[11:7];
        d.rs1       = insn[19:15];
        d.rs2       = insn[24:20];
        d.cls       = CLS_ILLEGAL;
        d.imm       = 32'd0;
        d.illegal   = 1'b0;
        case (insn[6:0])
            7'b0110111: begin d.cls = CLS_LUI;      d.imm = imm_u; end
            7'b0010111: begin d.cls = CLS_AUIPC;    d.imm = imm_u; end
            7'b1101111: begin d.cls = CLS_JAL;      d.imm = imm_j; end
            7'b1100111: begin d.cls = CLS_JALR;     d.imm = imm_i; end
            7'b1100011: begin d.cls = CLS_BRANCH;   d.imm = imm_b; d.rd = 5'd0; end
            7'b0000011: begin d.cls = CLS_LOAD;     d.imm = imm_i; end
            7'b0100011: begin d.cls = CLS_STORE;    d.imm = imm_s; d.rd = 5'd0; end
            7'b0010011: begin d.cls = CLS_OP_IMM;   d.imm = imm_i; end
            7'b0110011: begin d.cls = CLS_OP;       d.imm = 32'd0; end
            7'b0001111: begin d.cls = CLS_MISC_MEM; d.imm = imm_i; end
            7'b1110011: begin d.cls = CLS_SYSTEM;   d.imm = imm_i; end
            default: begin
                d.cls     = CLS_ILLEGAL;
                d.imm     = 32'd0;
                d.illegal = 1'b1;
            end
        endcase
        d.is_branch = (d.cls == CLS_JAL) || (d.cls == CLS_JALR) || (d.cls == CLS_BRANCH);
        return d;
    endfunction

    dec_t main_q;
    dec_t main_d;
    dec_t skid_q;
    dec_t skid_d;
    logic ex_valid_q;
    logic ex_valid_d;
    logic skid_valid_q;
    logic skid_valid_d;
    dec_t dec_s;
    logic accept_s;
    logic consume_s;

    assign dec_s     = decode_insn(in_insn, in_addr);
    assign in_ready  = !skid_valid_q;
    assign accept_s  = in_valid && !skid_valid_q;
    assign consume_s = ex_valid_q && ex_ready;

    // Route each new instruction to the main or skid register and track occupancy;
    // flush overrides everything and only drops the valids.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        ex_valid_d   = ex_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            ex_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid full means in_ready is low, so no accept can happen here
            if (consume_s) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                skid_valid_d = 1'b1;
            end
        end else if (accept_s) begin
            if (!ex_valid_q || consume_s) begin
                main_d     = dec_s;
                ex_valid_d = 1'b1;
            end else begin
                skid_d       = dec_s;
                skid_valid_d = 1'b1;
            end
        end else if (consume_s) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Output and skid registers; async reset clears valids and all data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            ex_valid_q   <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            ex_valid_q   <= ex_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_addr      = main_q.addr;
    assign ex_insn      = main_q.insn;
    assign ex_class     = main_q.cls;
    assign ex_rd        = main_q.rd;
    assign ex_rs1       = main_q.rs1;
    assign ex_rs2       = main_q.rs2;
    assign ex_imm       = main_q.imm;
    assign ex_is_branch = main_q.is_branch;
    assign ex_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed decode vectors, a stalled stream, flush,
// async reset and a randomized run, all checked against a queue-based model.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_addr;
    logic [31:0] in_insn;
    logic        ex_valid;
    logic        ex_ready;
    logic [29:0] ex_addr;
    logic [31:0] ex_insn;
    logic [3:0]  ex_class;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [31:0] ex_imm;
    logic        ex_is_branch;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] insn;
    } item_t;

    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        br;
        logic        ill;
    } exp_t;

    // Instructions held by the stage, oldest first (capacity two)
    item_t mq[$];

    decode_stage #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_insn(in_insn),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_insn(ex_insn),
        .ex_class(ex_class), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_imm(ex_imm), .ex_is_branch(ex_is_branch), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode using arithmetic shifts on the signed word
    function automatic exp_t ref_decode(input logic [31:0] insn);
        exp_t               e;
        logic signed [31:0] s;
        logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j, sgn;
        s     = insn;
        sgn   = 32'(s >>> 31);
        imm_i = 32'(s >>> 20);
        imm_s = (32'(s >>> 25) << 5) | 32'(insn[11:7]);
        imm_b = (sgn << 12) | (32'(insn[7]) << 11) | (32'(insn[30:25]) << 5) | (32'(insn[11:8]) << 1);
        imm_u = insn & 32'hFFFFF000;
        imm_j = (sgn << 20) | (32'(insn[19:12]) << 12) | (32'(insn[20]) << 11) | (32'(insn[30:21]) << 1);
        e.rd  = insn[11:7];
        e.rs1 = insn[19:15];
        e.rs2 = insn[24:20];
        e.cls = 4'd0;
        e.imm = 32'd0;
        e.ill = 1'b0;
        case (insn[6:0])
            7'h37: begin e.cls = 4'd1;  e.imm = imm_u; end
            7'h17: begin e.cls = 4'd2;  e.imm = imm_u; end
            7'h6F: begin e.cls = 4'd3;  e.imm = imm_j; end
            7'h67: begin e.cls = 4'd4;  e.imm = imm_i; end
            7'h63: begin e.cls = 4'd5;  e.imm = imm_b; e.rd = 5'd0; end
            7'h03: begin e.cls = 4'd6;  e.imm = imm_i; end
            7'h23: begin e.cls = 4'd7;  e.imm = imm_s; e.rd = 5'd0; end
            7'h13: begin e.cls = 4'd8;  e.imm = imm_i; end
            7'h33: begin e.cls = 4'd9;  end
            7'h0F: begin e.cls = 4'd10; e.imm = imm_i; end
            7'h73: begin e.cls = 4'd11; e.imm = imm_i; end
            default: e.ill = 1'b1;
        endcase
        e.br = (e.cls == 4'd3) || (e.cls == 4'd4) || (e.cls == 4'd5);
        return e;
    endfunction

    // Random instruction, usually with a valid opcode
    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 13);
        case (k)
            0:  r[6:0] = 7'h37;
            1:  r[6:0] = 7'h17;
            2:  r[6:0] = 7'h6F;
            3:  r[6:0] = 7'h67;
            4:  r[6:0] = 7'h63;
            5:  r[6:0] = 7'h03;
            6:  r[6:0] = 7'h23;
            7:  r[6:0] = 7'h13;
            8:  r[6:0] = 7'h33;
            9:  r[6:0] = 7'h0F;
            10: r[6:0] = 7'h73;
            default: r = r;
        endcase
        return r;
    endfunction

    // Drive inputs for the next rising edge and advance the model to match
    task automatic apply(input logic v, input logic [31:0] ins, input logic [29:0] a,
                         input logic rdy, input logic fl);
        bit    acc;
        item_t it;
        in_valid = v;
        in_insn  = ins;
        in_addr  = a;
        ex_ready = rdy;
        flush    = fl;
        acc      = v && (mq.size() < 2);
        if (fl) begin
            mq.delete();
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                it.addr = a;
                it.insn = ins;
                mq.push_back(it);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(1'b0, 32'd0, 30'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if ({ex_addr, ex_insn, ex_class, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_is_branch, ex_illegal} !== 115'd0) begin
            errors++; $display("FAIL reset_data got %h %h %h exp 0", ex_addr, ex_insn, ex_imm);
        end
        rst = 1'b0;
        mq.delete();
    endtask

    task automatic test_decode();
        logic [31:0] ins, imm;
        logic [29:0] a;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic        br, ill;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin ins = 32'h00500093; a = 30'h100; cls = 4'd8; rd = 5'd1;  imm = 32'h5;        br = 1'b0; ill = 1'b0; end
                1: begin ins = 32'hFE000EE3; a = 30'h104; cls = 4'd5; rd = 5'd0;  imm = 32'hFFFFFFFC; br = 1'b1; ill = 1'b0; end
                2: begin ins = 32'h123450B7; a = 30'h2AB; cls = 4'd1; rd = 5'd1;  imm = 32'h12345000; br = 1'b0; ill = 1'b0; end
                default: begin ins = (i == 3) ? 32'h00000000 : 32'hFFFFFFFF; a = 30'h3; cls = 4'd0; rd = 5'd0; imm = 32'd0; br = 1'b0; ill = 1'b1; end
            endcase
            @(negedge clk);
            apply(1'b1, ins, a, 1'b1, 1'b0);
            @(negedge clk);
            checks++;
            if ({ex_valid, ex_addr, ex_insn, ex_class, ex_rd, ex_imm, ex_is_branch, ex_illegal} !== {1'b1, a, ins, cls, rd, imm, br, ill}) begin
                errors++;
                $display("FAIL decode_%0d got v=%b a=%h c=%0d rd=%0d imm=%h br=%b ill=%b exp a=%h c=%0d rd=%0d imm=%h br=%b ill=%b",
                         i, ex_valid, ex_addr, ex_class, ex_rd, ex_imm, ex_is_branch, ex_illegal, a, cls, rd, imm, br, ill);
            end
            if (i == 0) begin
                checks++; if (ex_rs1 !== 5'd0) begin errors++; $display("FAIL decode_rs1 got %0d exp 0", ex_rs1); end
            end
            apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b0);
        end
        // 0xFFFFFFFF is also illegal; rd comes straight from insn[11:7]
        @(negedge clk);
        apply(1'b1, 32'hFFFFFFFF, 30'h7, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if ({ex_valid, ex_class, ex_rd, ex_imm, ex_illegal} !== {1'b1, 4'd0, 5'd31, 32'd0, 1'b1}) begin
            errors++; $display("FAIL decode_ones got c=%0d rd=%0d imm=%h ill=%b exp c=0 rd=31 imm=0 ill=1", ex_class, ex_rd, ex_imm, ex_illegal);
        end
        apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [8];
        logic [29:0] got_a [$];
        logic [31:0] got_i [$];
        exp_t        e;
        int          sent = 0;
        int          cyc = 0;
        int          last = -1;
        bit          saw_stall = 0;
        bit          rdy;
        bit          acc;
        for (int i = 0; i < 8; i++) ins[i] = rand_insn();
        while (got_i.size() < 8 && cyc < 60) begin
            @(negedge clk);
            checks++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %b exp %b", cyc, in_ready, mq.size() < 2); end
            checks++; if (ex_valid !== (mq.size() > 0)) begin errors++; $display("FAIL b2b_ex_valid cyc %0d got %b exp %b", cyc, ex_valid, mq.size() > 0); end
            if (in_ready === 1'b0) saw_stall = 1;
            rdy = !(cyc >= 3 && cyc < 6);
            if (ex_valid === 1'b1 && rdy) begin
                got_a.push_back(ex_addr);
                got_i.push_back(ex_insn);
                last = cyc;
            end
            if (mq.size() > 0) begin
                e = ref_decode(mq[0].insn);
                checks++;
                if ({ex_addr, ex_insn, ex_class, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_is_branch, ex_illegal} !== {mq[0].addr, mq[0].insn, e}) begin
                    errors++; $display("FAIL b2b_fields cyc %0d got %h %h c=%0d imm=%h exp %h %h c=%0d imm=%h",
                                       cyc, ex_addr, ex_insn, ex_class, ex_imm, mq[0].addr, mq[0].insn, e.cls, e.imm);
                end
            end
            if (sent < 8) begin
                acc = mq.size() < 2;
                apply(1'b1, ins[sent], 30'h200 + 30'(sent), rdy, 1'b0);
                if (acc) sent++;
            end else begin
                apply(1'b0, 32'd0, 30'd0, rdy, 1'b0);
            end
            cyc++;
        end
        checks++; if (got_i.size() != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", got_i.size()); end
        for (int k = 0; k < got_i.size(); k++) begin
            checks++;
            if (got_i[k] !== ins[k] || got_a[k] !== 30'h200 + 30'(k)) begin
                errors++; $display("FAIL b2b_order idx %0d got %h@%h exp %h@%h", k, got_i[k], got_a[k], ins[k], 30'h200 + 30'(k));
            end
        end
        checks++; if (!saw_stall) begin errors++; $display("FAIL b2b_stall got in_ready never low exp low"); end
        checks++; if (last != 11) begin errors++; $display("FAIL b2b_rate got last delivery cycle %0d exp 11", last); end
        @(negedge clk);
        apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        @(negedge clk);
        apply(1'b1, 32'h00100113, 30'h10, 1'b0, 1'b0);
        @(negedge clk);
        apply(1'b1, 32'h00200193, 30'h11, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if ({in_ready, ex_valid} !== 2'b01) begin errors++; $display("FAIL flush_full got rdy=%b v=%b exp rdy=0 v=1", in_ready, ex_valid); end
        apply(1'b1, 32'hDEADC0B7, 30'h12, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if ({in_ready, ex_valid} !== 2'b10) begin errors++; $display("FAIL flush_clear got rdy=%b v=%b exp rdy=1 v=0", in_ready, ex_valid); end
        apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got v=%b insn=%h exp v=0", ex_valid, ex_insn); end
        // Flush with an accept into an empty stage also drops the accept
        apply(1'b1, 32'h00300213, 30'h13, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_accept got v=%b exp 0", ex_valid); end
        apply(1'b1, 32'h00400293, 30'h14, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({ex_valid, ex_insn} !== {1'b1, 32'h00400293}) begin errors++; $display("FAIL flush_resume got v=%b insn=%h exp v=1 insn=00400293", ex_valid, ex_insn); end
        apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        apply(1'b1, 32'h00500313, 30'h20, 1'b0, 1'b0);
        @(negedge clk);
        apply(1'b1, 32'h00600393, 30'h21, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        mq.delete();
        apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b0);
        #1;
        checks++; if ({ex_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL async_rst got v=%b rdy=%b exp v=0 rdy=1", ex_valid, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 32'h00700413, 30'h22, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if ({ex_valid, ex_insn, ex_addr} !== {1'b1, 32'h00700413, 30'h22}) begin errors++; $display("FAIL async_rst_resume got v=%b insn=%h exp v=1 insn=00700413", ex_valid, ex_insn); end
        apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        exp_t e;
        int   bad = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mq.size() > 0) e = ref_decode(mq[0].insn);
            checks++;
            if (in_ready !== (mq.size() < 2) || ex_valid !== (mq.size() > 0) ||
                (mq.size() > 0 && {ex_addr, ex_insn, ex_class, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_is_branch, ex_illegal} !== {mq[0].addr, mq[0].insn, e})) begin
                errors++;
                if (bad < 10) $display("FAIL random cyc %0d got rdy=%b v=%b insn=%h imm=%h exp depth=%0d", c, in_ready, ex_valid, ex_insn, ex_imm, mq.size());
                bad++;
            end
            apply($urandom_range(0, 3) != 0, rand_insn(), 30'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b1);
        @(negedge clk);
        apply(1'b0, 32'd0, 30'd0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
